// File: rtl/b_run_handshake.sv
// Fast-domain burst responder: runs RUN_CYCLES compute-enable cycles per start pulse,
// then performs a four-phase done request/acknowledge handshake toward the a_clk domain.
module b_run_handshake #(
  parameter int RUN_CYCLES  = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             b_clk,
  input  logic             glb_arst_n,
  input  logic             b_ena_in,
  input  logic             a_ack,
  input  logic             b_err_clr,
  output logic             b_run,
  output logic [CNT_W-1:0] b_step,
  output logic             b_done_req,
  output logic             b_busy,
  output logic             b_ovr_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // Last step index, truncated to the counter width so RUN_CYCLES = 2^CNT_W still terminates.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(RUN_CYCLES - 1);

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic                   err_r;
  logic                   err_s;
  logic                   overrun_s;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;

  // Acknowledge synchronizer chain; only its last stage feeds the FSM.
  always_ff @(posedge b_clk or negedge glb_arst_n) begin
    if (!glb_arst_n) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], a_ack};
    end
  end

  assign ack_s = ack_sync_r[SYNC_STAGES-1];

  // Next-state, step counter and sticky overrun flag.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    err_s     = err_r;
    overrun_s = b_ena_in && (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (b_ena_in) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_STEP) begin
          state_s = ST_REQ;
          cnt_s   = '0;
        end else begin
          state_s = ST_RUN;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      // A stale high ack still costs one REQ cycle, so the request is always visible.
      ST_REQ: begin
        if (ack_s) begin
          state_s = ST_REL;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REL;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
    if (overrun_s) begin
      err_s = 1'b1;
    end else if (b_err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Controller state registers.
  always_ff @(posedge b_clk or negedge glb_arst_n) begin
    if (!glb_arst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge b_clk or negedge glb_arst_n) begin
    if (!glb_arst_n) begin
      b_run      <= 1'b0;
      b_step     <= '0;
      b_done_req <= 1'b0;
      b_busy     <= 1'b0;
      b_ovr_err  <= 1'b0;
    end else begin
      b_run      <= (state_r == ST_RUN);
      b_step     <= (state_r == ST_RUN) ? cnt_r : '0;
      b_done_req <= (state_r == ST_REQ);
      b_busy     <= (state_r != ST_IDLE);
      b_ovr_err  <= err_r;
    end
  end

endmodule

// File: tb/tb_b_run_handshake.sv
// Bench for b_run_handshake: three parameterisations driven by shared stimulus and
// checked every cycle against a timestamp-based model, plus directed literal checks.
module tb_b_run_handshake;

  logic b_clk;
  logic glb_arst_n;
  logic b_ena_in;
  logic a_ack;
  logic b_err_clr;

  logic       run_o  [3];
  logic [7:0] step_o [3];
  logic       req_o  [3];
  logic       busy_o [3];
  logic       err_o  [3];

  int n_chk;
  int n_fail;
  bit cmp_en;

  b_run_handshake #(.RUN_CYCLES(4), .CNT_W(8), .SYNC_STAGES(2)) u_r4 (
    .b_clk(b_clk), .glb_arst_n(glb_arst_n), .b_ena_in(b_ena_in), .a_ack(a_ack),
    .b_err_clr(b_err_clr), .b_run(run_o[0]), .b_step(step_o[0]), .b_done_req(req_o[0]),
    .b_busy(busy_o[0]), .b_ovr_err(err_o[0]));

  b_run_handshake #(.RUN_CYCLES(1), .CNT_W(8), .SYNC_STAGES(3)) u_r1 (
    .b_clk(b_clk), .glb_arst_n(glb_arst_n), .b_ena_in(b_ena_in), .a_ack(a_ack),
    .b_err_clr(b_err_clr), .b_run(run_o[1]), .b_step(step_o[1]), .b_done_req(req_o[1]),
    .b_busy(busy_o[1]), .b_ovr_err(err_o[1]));

  b_run_handshake #(.RUN_CYCLES(256), .CNT_W(8), .SYNC_STAGES(2)) u_r256 (
    .b_clk(b_clk), .glb_arst_n(glb_arst_n), .b_ena_in(b_ena_in), .a_ack(a_ack),
    .b_err_clr(b_err_clr), .b_run(run_o[2]), .b_step(step_o[2]), .b_done_req(req_o[2]),
    .b_busy(busy_o[2]), .b_ovr_err(err_o[2]));

  initial begin
    b_clk = 1'b0;
    forever #5 b_clk = ~b_clk;
  end

  function automatic int rc_of(int i);
    case (i)
      0: return 4;
      1: return 1;
      default: return 256;
    endcase
  endfunction

  function automatic int ss_of(int i);
    case (i)
      1: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a burst is described by its accept edge t0; phase follows from elapsed time,
  // the handshake from a history of sampled a_ack values delayed by the sync depth.
  int cyc;
  int last_rst;
  bit ackh [1024];
  bit act  [3];
  int t0   [3];
  bit reqd [3];
  bit err  [3];
  int pend_run [3], pend_step [3], pend_req [3], pend_busy [3], pend_err [3];
  int exp_run  [3], exp_step  [3], exp_req  [3], exp_busy  [3], exp_err  [3];

  // 0 idle, 1 running, 2 requesting, 3 releasing -- phase after edge x
  function automatic int phase_at(int i, int x);
    if (!act[i]) return 0;
    if (x <= t0[i] + rc_of(i) - 1) return 1;
    if (!reqd[i]) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; reqd[i] = 1'b0; err[i] = 1'b0; t0[i] = 0;
      pend_run[i] = 0; pend_step[i] = 0; pend_req[i] = 0; pend_busy[i] = 0; pend_err[i] = 0;
      exp_run[i]  = 0; exp_step[i]  = 0; exp_req[i]  = 0; exp_busy[i]  = 0; exp_err[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int e;
    int cur;
    int nxt;
    int s;
    bit acks;
    e = cyc;
    ackh[e % 1024] = a_ack;
    for (int i = 0; i < 3; i++) begin
      exp_run[i] = pend_run[i]; exp_step[i] = pend_step[i]; exp_req[i] = pend_req[i];
      exp_busy[i] = pend_busy[i]; exp_err[i] = pend_err[i];
      s = ss_of(i);
      acks = (e - s > last_rst) ? ackh[(e - s) % 1024] : 1'b0;
      cur = phase_at(i, e - 1);
      if (b_ena_in && cur != 0) err[i] = 1'b1;
      else if (b_err_clr) err[i] = 1'b0;
      if (b_ena_in && cur == 0) begin
        act[i] = 1'b1; t0[i] = e; reqd[i] = 1'b0;
      end
      if (cur == 2 && acks) reqd[i] = 1'b1;
      if (cur == 3 && !acks) act[i] = 1'b0;
      nxt = phase_at(i, e);
      pend_run[i]  = (nxt == 1) ? 1 : 0;
      pend_step[i] = (nxt == 1) ? e - t0[i] : 0;
      pend_req[i]  = (nxt == 2) ? 1 : 0;
      pend_busy[i] = (nxt != 0) ? 1 : 0;
      pend_err[i]  = err[i] ? 1 : 0;
    end
  endtask

  initial begin
    cyc = 0;
    last_rst = 0;
    model_clear();
    forever begin
      @(posedge b_clk or negedge glb_arst_n);
      if (b_clk === 1'b1) cyc++;
      if (glb_arst_n !== 1'b1) begin
        model_clear();
        last_rst = cyc;
      end else begin
        model_edge();
      end
    end
  end

  initial begin
    forever begin
      @(negedge b_clk);
      if (cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("run[%0d]@%0d", i, cyc),  {31'd0, run_o[i]},  exp_run[i]);
          chk($sformatf("step[%0d]@%0d", i, cyc), {24'd0, step_o[i]}, exp_step[i]);
          chk($sformatf("req[%0d]@%0d", i, cyc),  {31'd0, req_o[i]},  exp_req[i]);
          chk($sformatf("busy[%0d]@%0d", i, cyc), {31'd0, busy_o[i]}, exp_busy[i]);
          chk($sformatf("err[%0d]@%0d", i, cyc),  {31'd0, err_o[i]},  exp_err[i]);
        end
      end
    end
  end

  task automatic zero_chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_run[%0d]", tag, i),  {31'd0, run_o[i]},  32'd0);
      chk($sformatf("%s_step[%0d]", tag, i), {24'd0, step_o[i]}, 32'd0);
      chk($sformatf("%s_req[%0d]", tag, i),  {31'd0, req_o[i]},  32'd0);
      chk($sformatf("%s_busy[%0d]", tag, i), {31'd0, busy_o[i]}, 32'd0);
      chk($sformatf("%s_err[%0d]", tag, i),  {31'd0, err_o[i]},  32'd0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge b_clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cmp_en = 1'b0;
    glb_arst_n = 1'b0; b_ena_in = 1'b0; a_ack = 1'b0; b_err_clr = 1'b0;
    tick(3);
    zero_chk("reset");
    cmp_en = 1'b1;
    glb_arst_n = 1'b1;
    tick(3);

    // burst accepted at edge E
    b_ena_in = 1'b1; tick(1); b_ena_in = 1'b0;
    tick(1);
    chk("lit_r4_run_e1", {31'd0, run_o[0]}, 32'd1);
    chk("lit_r4_step_e1", {24'd0, step_o[0]}, 32'd0);
    chk("lit_r1_run_e1", {31'd0, run_o[1]}, 32'd1);
    b_ena_in = 1'b1; tick(1); b_ena_in = 1'b0;
    chk("lit_r4_step_e2", {24'd0, step_o[0]}, 32'd1);
    chk("lit_r1_run_e2", {31'd0, run_o[1]}, 32'd0);
    chk("lit_r1_req_e2", {31'd0, req_o[1]}, 32'd1);
    tick(1);
    chk("lit_r4_ovr_e3", {31'd0, err_o[0]}, 32'd1);
    chk("lit_r4_step_e3", {24'd0, step_o[0]}, 32'd2);
    tick(1);
    chk("lit_r4_step_e4", {24'd0, step_o[0]}, 32'd3);
    tick(1);
    chk("lit_r4_run_e5", {31'd0, run_o[0]}, 32'd0);
    chk("lit_r4_req_e5", {31'd0, req_o[0]}, 32'd1);
    b_err_clr = 1'b1; tick(1); b_err_clr = 1'b0;
    tick(1);
    chk("lit_r4_clr_e7", {31'd0, err_o[0]}, 32'd0);
    b_ena_in = 1'b1; b_err_clr = 1'b1; tick(1);
    b_ena_in = 1'b0; b_err_clr = 1'b0; tick(1);
    chk("lit_r4_setwins_e9", {31'd0, err_o[0]}, 32'd1);
    chk("lit_r4_req_e9", {31'd0, req_o[0]}, 32'd1);
    a_ack = 1'b1; tick(3);
    chk("lit_r4_req_e12", {31'd0, req_o[0]}, 32'd1);
    tick(1);
    chk("lit_r4_req_e13", {31'd0, req_o[0]}, 32'd0);
    chk("lit_r4_busy_e13", {31'd0, busy_o[0]}, 32'd1);
    tick(7);
    a_ack = 1'b0; b_err_clr = 1'b1; tick(1);
    b_err_clr = 1'b0; tick(1);
    b_ena_in = 1'b1;
    chk("lit_r4_err_e22", {31'd0, err_o[0]}, 32'd0);
    tick(1);
    chk("lit_r4_busy_e23", {31'd0, busy_o[0]}, 32'd1);
    tick(1);
    b_ena_in = 1'b0;
    chk("lit_r4_relidle_ovr_e24", {31'd0, err_o[0]}, 32'd1);
    chk("lit_r4_busy_e24", {31'd0, busy_o[0]}, 32'd0);
    tick(1);
    chk("lit_r4_restart_e25", {31'd0, run_o[0]}, 32'd1);
    tick(231);
    chk("lit_r256_step_e256", {24'd0, step_o[2]}, 32'd255);
    chk("lit_r256_run_e256", {31'd0, run_o[2]}, 32'd1);
    tick(1);
    chk("lit_r256_run_e257", {31'd0, run_o[2]}, 32'd0);
    chk("lit_r256_req_e257", {31'd0, req_o[2]}, 32'd1);
    chk("lit_r256_step_e257", {24'd0, step_o[2]}, 32'd0);
    a_ack = 1'b1; tick(6); a_ack = 1'b0; tick(8);

    // reset in the middle of a burst
    b_ena_in = 1'b1; tick(1); b_ena_in = 1'b0; tick(3);
    #2 glb_arst_n = 1'b0;
    #1 zero_chk("midrun_rst");
    tick(2);
    glb_arst_n = 1'b1;
    tick(12);
    chk("lit_r4_noreq_after_rst", {31'd0, req_o[0]}, 32'd0);
    chk("lit_r4_idle_after_rst", {31'd0, busy_o[0]}, 32'd0);
    b_ena_in = 1'b1; tick(1); b_ena_in = 1'b0; tick(1);
    chk("lit_r4_run_after_rst", {31'd0, run_o[0]}, 32'd1);
    tick(3);
    chk("lit_r4_step3_after_rst", {24'd0, step_o[0]}, 32'd3);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      b_ena_in  = ($urandom_range(0, 7) == 0);
      b_err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) a_ack = ~a_ack;
      if (glb_arst_n == 1'b0) begin
        glb_arst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        #2 glb_arst_n = 1'b0;
        #1 zero_chk("rand_rst");
      end
      tick(1);
    end
    glb_arst_n = 1'b1; b_ena_in = 1'b0; b_err_clr = 1'b0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/b_run_handshake.md
# b_run_handshake

Fast-domain (b_clk) responder for the slow-to-fast trigger path. It consumes the single-cycle b_clk enable pulse delivered by the trigger synchronizer and runs a fixed-length burst of compute-enable cycles. On completion it raises a four-phase done request back toward the slow (a_clk) domain and holds it until the slow side acknowledges. The block sits between the trigger synchronizer output and the fast-clock arithmetic pipeline, and closes the return half of the cross-domain handshake.

## Interface
- RUN_CYCLES, 16, number of b_run cycles per burst; legal range 1..2^CNT_W.
- CNT_W, 8, width of the step counter.
- SYNC_STAGES, 2, flops in the a_ack synchronizer; minimum 2.

- b_clk  in  1  the single clock; all state is on its rising edge.
- glb_arst_n  in  1  asynchronous, active-low reset for the whole block.
- b_ena_in  in  1  single-cycle start pulse, synchronous to b_clk.
- a_ack  in  1  acknowledge level from the a_clk domain; asynchronous to b_clk, synchronized internally.
- b_err_clr  in  1  synchronous clear of b_ovr_err.
- b_run  out  1  compute enable; high for exactly RUN_CYCLES consecutive cycles per accepted start.
- b_step  out  CNT_W  index of the current run cycle, 0..RUN_CYCLES-1; 0 when not running.
- b_done_req  out  1  done request level toward the a_clk domain.
- b_busy  out  1  high in any state other than IDLE.
- b_ovr_err  out  1  sticky flag: a start arrived while busy.

## Operation
- States:
  - IDLE: all outputs low.
  - RUN: b_run=1.
  - REQ: b_done_req=1, waiting for the synchronized ack to go high.
  - REL: b_done_req=0, waiting for the synchronized ack to go low.
- Transitions:
  - IDLE→RUN on b_ena_in=1; b_step loads 0.
  - RUN: b_step increments each cycle. When b_step==RUN_CYCLES-1, go to REQ on the next edge.
  - REQ→REL when ack_s=1.
  - REL→IDLE when ack_s=0.
- ack_s is a_ack passed through a SYNC_STAGES flop chain clocked by b_clk. Only ack_s is used in logic; the raw a_ack is never used.
- Start while busy (RUN/REQ/REL):
  - The start is ignored; the burst is neither restarted nor extended.
  - b_ovr_err is set on the next edge.
- b_ovr_err clearing:
  - b_err_clr=1 clears it.
  - If b_err_clr and an overrun start occur in the same cycle, set wins.
- Start on the same edge the FSM returns REL→IDLE: the start is ignored and counted as an overrun, because the FSM is still in REL when the pulse is sampled.
- ack_s already high on entry to REQ (stale ack): the FSM must still pass through REQ for at least one cycle with b_done_req=1, then go to REL. This means no b_done_req glitch is skipped.
- b_step is reset to 0 on RUN exit and must never reach RUN_CYCLES.
- The counter compares against RUN_CYCLES-1 computed at CNT_W bits. RUN_CYCLES=1 gives a one-cycle burst.

## Timing
- Reset:
  - glb_arst_n=0 forces IDLE immediately.
  - Outputs during reset: b_run=0, b_step=0, b_done_req=0, b_busy=0, b_ovr_err=0, and all synchronizer flops 0.
  - Reset mid-burst or mid-handshake abandons the burst; no done request is issued.
  - Deassertion is taken on the b_clk edge following glb_arst_n rising.
- Start pulse sampled at edge t:
  - b_run and b_busy are high from edge t+1 through edge t+RUN_CYCLES.
  - b_step equals k during the k-th cycle after t+1.
- b_done_req rises at edge t+RUN_CYCLES+1.
- a_ack rising before edge e is seen as ack_s=1 after SYNC_STAGES edges. b_done_req falls one edge later, so the worst-case ack-to-request-drop latency is SYNC_STAGES+1 cycles.
- The a_ack falling edge has the same latency to the return to IDLE. b_busy falls on the same edge as the return to IDLE.
- Every output is registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic burst, RUN_CYCLES=4: one b_ena_in pulse at edge 10 → b_run high over edges 11–14, b_step 0,1,2,3, b_done_req rises at edge 15. a_ack raised at 20 and dropped at 30 → b_done_req falls at edge 23, b_busy falls at edge 33.
- Overrun: second b_ena_in at edge 12 → burst unchanged, b_ovr_err=1 from edge 13. Pulse b_err_clr → flag 0 on the next edge. Simultaneous b_err_clr and overrun start → flag stays 1.
- Stale ack: a_ack held high before the burst ends → b_done_req is high for exactly one cycle, then REL. IDLE is reached SYNC_STAGES+1 cycles after a_ack drops.
- Reset mid-RUN: glb_arst_n low at step 2 → all outputs 0 immediately. After release, no b_done_req appears, and a new start runs a full burst.
- Edge parameters: RUN_CYCLES=1 → single b_run cycle with b_step=0. RUN_CYCLES=256 with CNT_W=8 → b_step reaches 255 with no wrap, b_done_req follows.
- Start on the REL→IDLE edge → ignored, b_ovr_err=1. The next start one cycle later is accepted.
